// File: rtl/ram_pkg.sv
// Shared types for the general-depth data memory.
package ram_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } ram_state_t;

endpackage

// File: rtl/ram_nw_regst.sv
// Single WIDTH-bit storage register loaded on a clock edge while st is high.
module regst #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             st,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] out
);

  always_ff @(posedge clk) begin
    if (st) out <= d;
  end

endmodule

// File: rtl/ram_nw.sv
// DEPTH x WIDTH single-port RAM with combinational read, synchronous reset,
// a hardware clear sequencer that zeroes one word per cycle, and a write-drop flag.
module ram_nw
  import ram_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic                     st,
  input  logic                     clr,
  input  logic [WIDTH-1:0]         x,
  output logic [WIDTH-1:0]         out,
  output logic                     busy,
  output logic                     wr_drop
);

  localparam int AW = $clog2(DEPTH);

  ram_state_t          state_q, state_d;
  logic [AW-1:0]       ptr_q, ptr_d;
  logic                wr_drop_q, wr_drop_d;
  logic                addr_oob;
  logic [WIDTH-1:0]    word_d;
  logic [DEPTH-1:0]    word_st;
  logic [WIDTH-1:0]    word_q [DEPTH];

  assign busy     = (state_q == CLEAR);
  assign addr_oob = (32'(addr) >= 32'(DEPTH));
  assign wr_drop  = wr_drop_q;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    wr_drop_d = st && (busy || addr_oob);
    unique case (state_q)
      IDLE: begin
        if (clr) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end
      end
      CLEAR: begin
        if (ptr_q == AW'(DEPTH - 1)) begin
          state_d = IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + AW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR;
      ptr_q     <= '0;
      wr_drop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      wr_drop_q <= wr_drop_d;
    end
  end

  assign word_d = busy ? '0 : x;

  // Word enables are suppressed under rst so a held reset leaves the array untouched.
  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    assign word_st[i] = !rst && (busy ? (ptr_q == AW'(i))
                                      : (st && (addr == AW'(i))));
    regst #(.WIDTH(WIDTH)) u_word (
      .clk (clk),
      .st  (word_st[i]),
      .d   (word_d),
      .out (word_q[i])
    );
  end

  always_comb begin
    out = '0;
    if (!busy && !addr_oob) out = word_q[addr];
  end

endmodule

// File: tb/tb_ram_nw.sv
// Directed self-checking bench for ram_nw at DEPTH=8 and DEPTH=5.
module tb_ram_nw;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, st, clr, busy, wr_drop;
  logic [2:0]  addr;
  logic [15:0] x, out;

  logic        rst5, st5, clr5, busy5, wr_drop5;
  logic [2:0]  addr5;
  logic [15:0] x5, out5;

  int checks   = 0;
  int failures = 0;

  ram_nw #(.WIDTH(16), .DEPTH(8)) dut (
    .clk(clk), .rst(rst), .addr(addr), .st(st), .clr(clr), .x(x),
    .out(out), .busy(busy), .wr_drop(wr_drop)
  );

  ram_nw #(.WIDTH(16), .DEPTH(5)) dut5 (
    .clk(clk), .rst(rst5), .addr(addr5), .st(st5), .clr(clr5), .x(x5),
    .out(out5), .busy(busy5), .wr_drop(wr_drop5)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; st = 1'b1; addr = 3'd3; x = 16'hDEAD;
    step();
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL reset_busy got=%b exp=1", busy); end
    checks++;
    if (out !== 16'h0) begin failures++; $display("FAIL reset_out got=%h exp=0000", out); end
    checks++;
    if (wr_drop !== 1'b0) begin failures++; $display("FAIL reset_wr_drop got=%b exp=0", wr_drop); end
    step();
    st = 1'b0; rst = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL reset_busy_release got=%b exp=1", busy); end
    for (int k = 1; k <= 8; k++) begin
      step();
      checks++;
      if (busy !== (k < 8)) begin
        failures++; $display("FAIL reset_busy_len edge=%0d got=%b exp=%b", k, busy, (k < 8));
      end
    end
    checks++;
    if (wr_drop !== 1'b0) begin failures++; $display("FAIL reset_no_drop got=%b exp=0", wr_drop); end
    for (int a = 0; a < 8; a++) begin
      addr = 3'(a);
      #1;
      checks++;
      if (out !== 16'h0) begin failures++; $display("FAIL reset_zero addr=%0d got=%h exp=0000", a, out); end
    end
  endtask

  task automatic test_write_read();
    addr = 3'd3; x = 16'hBEEF; st = 1'b1;
    #1;
    checks++;
    if (out !== 16'h0) begin failures++; $display("FAIL wr_no_bypass got=%h exp=0000", out); end
    step();
    st = 1'b0;
    #1;
    checks++;
    if (out !== 16'hBEEF) begin failures++; $display("FAIL wr_read3 got=%h exp=beef", out); end
    checks++;
    if (wr_drop !== 1'b0) begin failures++; $display("FAIL wr_no_drop got=%b exp=0", wr_drop); end
    addr = 3'd2;
    #1;
    checks++;
    if (out !== 16'h0) begin failures++; $display("FAIL wr_read2 got=%h exp=0000", out); end
  endtask

  task automatic test_clear();
    for (int i = 0; i < 8; i++) begin
      addr = 3'(i); x = {8'h00, 4'(i), 4'h1}; st = 1'b1;
      step();
    end
    st = 1'b0; addr = 3'd6;
    #1;
    checks++;
    if (out !== 16'h0061) begin failures++; $display("FAIL clear_fill6 got=%h exp=0061", out); end
    clr = 1'b1;
    step();
    clr = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL clear_busy_start got=%b exp=1", busy); end
    for (int k = 1; k <= 8; k++) begin
      step();
      checks++;
      if (busy !== (k < 8)) begin
        failures++; $display("FAIL clear_busy_len edge=%0d got=%b exp=%b", k, busy, (k < 8));
      end
    end
    for (int a = 0; a < 8; a++) begin
      addr = 3'(a);
      #1;
      checks++;
      if (out !== 16'h0) begin failures++; $display("FAIL clear_zero addr=%0d got=%h exp=0000", a, out); end
    end
  endtask

  task automatic test_drop();
    bit done;
    addr = 3'd1; x = 16'h5555; st = 1'b1;
    step();
    st = 1'b0; clr = 1'b1;
    step();
    clr = 1'b0;
    step(); step(); step();
    addr = 3'd1; x = 16'h1234; st = 1'b1;
    step();
    st = 1'b0;
    checks++;
    if (wr_drop !== 1'b1) begin failures++; $display("FAIL drop_flag got=%b exp=1", wr_drop); end
    step();
    checks++;
    if (wr_drop !== 1'b0) begin failures++; $display("FAIL drop_pulse got=%b exp=0", wr_drop); end
    done = 1'b0;
    for (int k = 0; k < 12 && !done; k++) begin
      if (!busy) done = 1'b1;
      else step();
    end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL drop_timeout busy=%b exp=0", busy); end
    addr = 3'd1;
    #1;
    checks++;
    if (out !== 16'h0) begin failures++; $display("FAIL drop_word1 got=%h exp=0000", out); end
  endtask

  task automatic test_rst_midclear();
    addr = 3'd7; x = 16'h7777; st = 1'b1;
    step();
    st = 1'b0; clr = 1'b1;
    step();
    clr = 1'b0;
    step(); step(); step();
    rst = 1'b1; st = 1'b1; addr = 3'd2; x = 16'h2222;
    step();
    checks++;
    if (wr_drop !== 1'b0) begin failures++; $display("FAIL rstmid_drop_forced got=%b exp=0", wr_drop); end
    rst = 1'b0; st = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      clr = (k == 2);
      step();
      checks++;
      if (busy !== (k < 8)) begin
        failures++; $display("FAIL rstmid_busy_len edge=%0d got=%b exp=%b", k, busy, (k < 8));
      end
    end
    clr = 1'b0;
    addr = 3'd7;
    #1;
    checks++;
    if (out !== 16'h0) begin failures++; $display("FAIL rstmid_word7 got=%h exp=0000", out); end
    addr = 3'd2;
    #1;
    checks++;
    if (out !== 16'h0) begin failures++; $display("FAIL rstmid_word2 got=%h exp=0000", out); end
  endtask

  task automatic test_depth5();
    rst5 = 1'b1;
    step();
    rst5 = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step();
      checks++;
      if (busy5 !== (k < 5)) begin
        failures++; $display("FAIL d5_busy_len edge=%0d got=%b exp=%b", k, busy5, (k < 5));
      end
    end
    for (int i = 0; i < 5; i++) begin
      addr5 = 3'(i); x5 = 16'h00A0 + 16'(i); st5 = 1'b1;
      step();
    end
    addr5 = 3'd6; x5 = 16'hFFFF; st5 = 1'b1;
    #1;
    checks++;
    if (out5 !== 16'h0) begin failures++; $display("FAIL d5_oob_out got=%h exp=0000", out5); end
    step();
    st5 = 1'b0;
    checks++;
    if (wr_drop5 !== 1'b1) begin failures++; $display("FAIL d5_oob_drop got=%b exp=1", wr_drop5); end
    step();
    checks++;
    if (wr_drop5 !== 1'b0) begin failures++; $display("FAIL d5_drop_pulse got=%b exp=0", wr_drop5); end
    for (int i = 0; i < 5; i++) begin
      addr5 = 3'(i);
      #1;
      checks++;
      if (out5 !== 16'h00A0 + 16'(i)) begin
        failures++; $display("FAIL d5_word addr=%0d got=%h exp=%h", i, out5, 16'h00A0 + 16'(i));
      end
    end
  endtask

  initial begin
    rst = 1'b1; st = 1'b0; clr = 1'b0; addr = '0; x = '0;
    rst5 = 1'b1; st5 = 1'b0; clr5 = 1'b0; addr5 = '0; x5 = '0;
    test_reset();
    test_write_read();
    test_clear();
    test_drop();
    test_rst_midclear();
    test_depth5();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
